scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, 8, width of the dwell-count input.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  begin a scan when sampled high in IDLE.
REQ-005 Port: stop  input  1  abort the scan; has priority over start.
REQ-006 Port: loop  input  1  1 = repeat scans continuously; 0 = one pass then IDLE.
REQ-007 Port: mask  input  8  channel enable bits; bit i set = channel i visited.
REQ-008 Port: dwell  input  DWELL_W  active cycles per channel minus one.
REQ-009 Port: sel  output  3  channel code; drives the 3-to-8 decoder select input.
REQ-010 Port: sel_en_n  output  1  active-low decoder enable; low only while a channel is driven.
REQ-011 Port: busy  output  1  high in SCAN and GAP states.
REQ-012 Port: cycle_done  output  1  one-cycle pulse on completion of each pass over the mask.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 FSM states SHALL be IDLE, SCAN and GAP.
REQ-015 In IDLE, start=1, stop=0 and mask!=0 SHALL load sel with the lowest set mask bit, load the down-counter with dwell, drive sel_en_n=0 and busy=1, and go to SCAN.
REQ-016 In IDLE, start with mask==0 SHALL be ignored: state and outputs are unchanged.
REQ-017 In SCAN, the counter SHALL decrement once per cycle, so a channel stays active for dwell+1 cycles; dwell=0 gives 1 cycle.
REQ-018 In SCAN, when the counter reaches 0, the FSM SHALL go to GAP with sel_en_n=1 and sel held (break-before-make).
REQ-019 GAP SHALL last exactly 1 cycle.
REQ-020 In GAP, mask SHALL be re-sampled and the next channel chosen as the next set bit above sel, wrapping from 7 to 0.
REQ-021 A wrap SHALL occur when the next channel index is <= the current sel. This includes a single-bit mask revisiting the same channel.
REQ-022 On a wrap, cycle_done SHALL be high for exactly the one cycle following GAP.
REQ-023 After a wrap with loop=0, the FSM SHALL go to IDLE with sel held, sel_en_n=1 and busy=0.
REQ-024 After a wrap with loop=1, or with no wrap, the FSM SHALL go to SCAN with the new sel, the counter reloaded from dwell, and sel_en_n=0.
REQ-025 If mask==0 when sampled in GAP, the FSM SHALL go to IDLE with no cycle_done pulse.
REQ-026 stop=1 in any state SHALL force IDLE on the next edge: sel_en_n=1, busy=0, sel held, no cycle_done.
REQ-027 start and stop high in the same cycle in IDLE SHALL leave the FSM in IDLE.
REQ-028 dwell and loop SHALL be sampled only on load and reload; changes mid-dwell have no effect until the next channel.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 sel_en_n SHALL never be low in the same cycle that sel changes value.

Reset
REQ-031 rst_n=0 at a clock edge SHALL set state=IDLE, sel=3'b000, sel_en_n=1, busy=0, cycle_done=0 and counter=0.
REQ-032 Reset SHALL take effect from any state, including mid-dwell, and SHALL override start and stop.
REQ-033 No output SHALL change asynchronously to clk.

Verification
REQ-034 Reset: hold rst_n=0 for 2 cycles -> sel=0, sel_en_n=1, busy=0, cycle_done=0.
REQ-035 Single pass: mask=8'hFF, dwell=2, loop=0, 1-cycle start -> sel steps 0..7, each with sel_en_n low for 3 cycles then 1 GAP cycle; cycle_done pulses once after channel 7; busy high for 32 cycles then IDLE.
REQ-036 Sparse loop: mask=8'b1000_0100, dwell=0, loop=1 -> sel sequence 2,7,2,7,...; sel_en_n alternates low/high each cycle; cycle_done pulses after every visit to channel 7.
REQ-037 Abort: stop=1 during the 2nd dwell cycle of channel 3 (mask=8'hFF, dwell=4) -> next edge sel_en_n=1, busy=0, sel=3, no cycle_done.
REQ-038 Null starts: start with mask=0 -> no output change; start and stop high together in IDLE -> stays IDLE.
REQ-039 Mid-scan reset: rst_n=0 on one edge during SCAN on channel 5 -> all outputs at reset values on that edge, and the FSM remains IDLE until a new start.

Source files
------------

// File: rtl/scan_sequencer_if.sv
// Scan sequencer control/status bundle: the controller drives the request side (master),
// the sequencer returns registered decoder select and status (slave).
interface scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               loop;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               sel_en_n;
    logic               busy;
    logic               cycle_done;

    modport master (
        output start, stop, loop, mask, dwell,
        input  sel, sel_en_n, busy, cycle_done
    );

    modport slave (
        input  start, stop, loop, mask, dwell,
        output sel, sel_en_n, busy, cycle_done
    );
endinterface

// File: rtl/scan_sequencer.sv
// Walks a 3-to-8 decoder across the enabled channels, dwell+1 cycles each with a 1-cycle
// break-before-make gap; all outputs registered, one cycle after the deciding edge.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               loop_q, loop_d;
    logic               en_n_q, en_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               start_ok;
    logic [2:0]         first_ch;
    logic [2:0]         next_ch;
    logic               wrap;

    assign start_ok = bus.start && !bus.stop && (bus.mask != 8'h00);

    // Lowest set bit for a fresh scan; next set bit strictly above sel (modulo 8) in GAP.
    always_comb begin
        logic [2:0] cand;
        first_ch = 3'd0;
        next_ch  = sel_q;
        cand     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.mask[i]) first_ch = i[2:0];
        end
        for (int k = 8; k >= 1; k--) begin
            cand = sel_q + k[2:0];
            if (bus.mask[cand]) next_ch = cand;
        end
    end

    assign wrap = (next_ch <= sel_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            loop_q  <= 1'b0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            loop_q  <= loop_d;
            en_n_q  <= en_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = SCAN;
            SCAN: if (cnt_q == '0) state_d = GAP;
            GAP: begin
                if (bus.mask == 8'h00)      state_d = IDLE;
                else if (wrap && !loop_q)   state_d = IDLE;
                else                        state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
        if (bus.stop) state_d = IDLE;
    end

    always_comb begin
        sel_d  = sel_q;
        cnt_d  = cnt_q;
        loop_d = loop_q;
        en_n_d = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    sel_d  = first_ch;
                    cnt_d  = bus.dwell;
                    loop_d = bus.loop;
                    en_n_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            SCAN: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - DWELL_W'(1);
                    en_n_d = 1'b0;
                end
            end
            GAP: begin
                if (bus.mask != 8'h00) begin
                    done_d = wrap;
                    if (!wrap || loop_q) begin
                        sel_d  = next_ch;
                        cnt_d  = bus.dwell;
                        loop_d = bus.loop;
                        en_n_d = 1'b0;
                        busy_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // Abort parks the decoder on the current channel with no completion pulse.
        if (bus.stop) begin
            sel_d  = sel_q;
            cnt_d  = '0;
            en_n_d = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b0;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_en_n   = en_n_q;
    assign bus.busy       = busy_q;
    assign bus.cycle_done = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: hand-computed per-cycle {sel, sel_en_n, busy, cycle_done}.
module tb_scan_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   vec  = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    scan_sequencer_if #(.DWELL_W(8)) bus ();

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [5:0] obs();
        return {bus.sel, bus.sel_en_n, bus.busy, bus.cycle_done};
    endfunction

    function automatic logic [5:0] mk(input int ch, input logic en_n, input logic busy, input logic done);
        return {ch[2:0], en_n, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        bus.mask = 8'h00; bus.dwell = 8'd0;
        tick();
        tick();
        vec++; if (bus.sel !== 3'd0) begin miss++; $display("FAIL reset_sel got %0d want 0", bus.sel); end
        vec++; if (bus.sel_en_n !== 1'b1) begin miss++; $display("FAIL reset_en_n got %b want 1", bus.sel_en_n); end
        vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vec++; if (bus.cycle_done !== 1'b0) begin miss++; $display("FAIL reset_done got %b want 0", bus.cycle_done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        logic [5:0] exp;
        int busy_cnt = 0;
        bus.mask = 8'hFF; bus.dwell = 8'd2; bus.loop = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int ch = 0; ch < 8; ch++) begin
            for (int c = 0; c < 4; c++) begin
                exp = mk(ch, (c == 3), 1'b1, 1'b0);
                if (bus.busy === 1'b1) busy_cnt++;
                vec++;
                if (obs() !== exp) begin
                    miss++;
                    $display("FAIL pass ch%0d c%0d got %b want %b", ch, c, obs(), exp);
                end
                tick();
            end
        end
        vec++; if (busy_cnt != 32) begin miss++; $display("FAIL pass_busy_len got %0d want 32", busy_cnt); end
        exp = mk(7, 1'b1, 1'b0, 1'b1);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL pass_end got %b want %b", obs(), exp); end
        tick();
        exp = mk(7, 1'b1, 1'b0, 1'b0);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL pass_idle got %b want %b", obs(), exp); end
    endtask

    task automatic test_sparse_loop();
        logic [5:0] exp;
        bus.mask = 8'b1000_0100; bus.dwell = 8'd0; bus.loop = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            case (k % 4)
                0:       exp = mk(2, 1'b0, 1'b1, (k >= 4));
                1:       exp = mk(2, 1'b1, 1'b1, 1'b0);
                2:       exp = mk(7, 1'b0, 1'b1, 1'b0);
                default: exp = mk(7, 1'b1, 1'b1, 1'b0);
            endcase
            vec++;
            if (obs() !== exp) begin miss++; $display("FAIL sparse k%0d got %b want %b", k, obs(), exp); end
            tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        exp = mk(2, 1'b1, 1'b0, 1'b0);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL sparse_stop got %b want %b", obs(), exp); end
    endtask

    task automatic test_abort();
        logic [5:0] exp;
        bus.mask = 8'hFF; bus.dwell = 8'd4; bus.loop = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        exp = mk(3, 1'b0, 1'b1, 1'b0);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL abort_pre got %b want %b", obs(), exp); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        exp = mk(3, 1'b1, 1'b0, 1'b0);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL abort got %b want %b", obs(), exp); end
        tick();
        tick();
        vec++; if (obs() !== exp) begin miss++; $display("FAIL abort_hold got %b want %b", obs(), exp); end
    endtask

    task automatic test_null_starts();
        logic [5:0] exp;
        exp = mk(3, 1'b1, 1'b0, 1'b0);
        bus.mask = 8'h00; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        vec++; if (obs() !== exp) begin miss++; $display("FAIL null_mask got %b want %b", obs(), exp); end
        tick();
        vec++; if (obs() !== exp) begin miss++; $display("FAIL null_mask_hold got %b want %b", obs(), exp); end
        bus.mask = 8'hFF; bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        vec++; if (obs() !== exp) begin miss++; $display("FAIL start_stop got %b want %b", obs(), exp); end
        tick();
        vec++; if (obs() !== exp) begin miss++; $display("FAIL start_stop_hold got %b want %b", obs(), exp); end
    endtask

    task automatic test_dwell_sampling();
        logic [5:0] exp;
        bus.mask = 8'h03; bus.dwell = 8'd1; bus.loop = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.dwell = 8'd3;
        for (int c = 0; c < 8; c++) begin
            exp = mk((c < 3) ? 0 : 1, (c == 2 || c == 7), 1'b1, 1'b0);
            vec++;
            if (obs() !== exp) begin miss++; $display("FAIL dwell_smp c%0d got %b want %b", c, obs(), exp); end
            tick();
        end
        exp = mk(1, 1'b1, 1'b0, 1'b1);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL dwell_smp_end got %b want %b", obs(), exp); end
        tick();
    endtask

    task automatic test_midscan_reset();
        logic [5:0] exp;
        bus.mask = 8'hFF; bus.dwell = 8'd4; bus.loop = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        exp = mk(5, 1'b0, 1'b1, 1'b0);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL mrst_pre got %b want %b", obs(), exp); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp = mk(0, 1'b1, 1'b0, 1'b0);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL mrst got %b want %b", obs(), exp); end
        tick();
        tick();
        tick();
        vec++; if (obs() !== exp) begin miss++; $display("FAIL mrst_hold got %b want %b", obs(), exp); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp = mk(0, 1'b0, 1'b1, 1'b0);
        vec++; if (obs() !== exp) begin miss++; $display("FAIL mrst_restart got %b want %b", obs(), exp); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_sparse_loop();
        test_abort();
        test_null_starts();
        test_dwell_sampling();
        test_midscan_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
